uart_tx_port: RTL

Serial transmitter peripheral on the microcontroller's output-port bus: the core's port writes (data byte plus port select) are consumed here, buffered in a small FIFO and shifted out as 8N1 UART frames on `tx`. An 8-bit status word is returned for wiring to one of the core's `ein` input ports, so firmware can poll FIFO space and busy state. Sits beside the output registers, driven by the same enable/port strobe.

---
 rtl/uart_tx_pkg.sv | 34 +++
 rtl/uart_tx_port_if.sv | 11 +
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_tx_port.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter port: FSM states, port addresses,
// and the status and CTRL bit positions. Optional parity: UART_TX_PARITY_EN.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } txState_t;

    localparam logic [1:0] PORT_DATA   = 2'd0;
    localparam logic [1:0] PORT_DIV_LO = 2'd1;
    localparam logic [1:0] PORT_DIV_HI = 2'd2;
    localparam logic [1:0] PORT_CTRL   = 2'd3;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 4;

    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_CLR_OVF = 1;

    // A programmed divisor of zero runs at one clock per bit.
    function automatic logic [15:0] effDivisor(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_tx_port_if.sv
// Core-side port-write bus plus the status word and serial line of the transmitter.
interface uart_tx_port_if;
    logic       wr_en;
    logic [1:0] wr_port;
    logic [7:0] wr_data;
    logic [7:0] status;
    logic       tx;

    modport master (output wr_en, output wr_port, output wr_data, input status, input tx);
    modport slave  (input wr_en, input wr_port, input wr_data, output status, output tx);
endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO (depth 2 or 4) with push, pop and flush.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_flush,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_full,
    output logic       o_empty,
    output logic [2:0] o_count
);
    localparam int AW = (DEPTH > 2) ? 2 : 1;

    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [2:0]    r_count;
    logic [7:0]    r_mem [DEPTH];
    logic          w_doPush;
    logic          w_doPop;

    assign o_full   = (r_count == 3'(DEPTH));
    assign o_empty  = (r_count == 3'd0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];
    assign w_doPop  = i_pop && !o_empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign w_doPush = i_push && !i_flush && (!o_full || w_doPop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= 3'd0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= 3'd0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_data;
    end

endmodule

// File: rtl/uart_tx_port.sv
// UART 8N1 transmitter on the output-port bus: register decode, divisor, bit timer,
// frame FSM and shifter. Define UART_TX_PARITY_EN to add an even-parity bit.
module uart_tx_port
    import uart_tx_pkg::*;
#(
    parameter logic [15:0] CLK_DIV    = 16'd434,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_port_if.slave   bus
);
    txState_t    r_state;
    txState_t    w_nextState;
    logic [15:0] r_div;
    logic [15:0] r_timer;
    logic [7:0]  r_shift;
    logic [2:0]  r_bitIdx;
    logic        r_overflow;
`ifdef UART_TX_PARITY_EN
    logic        r_parity;
`endif

    logic        w_push;
    logic        w_pop;
    logic        w_flush;
    logic        w_clrOvf;
    logic        w_full;
    logic        w_empty;
    logic [2:0]  w_count;
    logic [7:0]  w_fifoData;
    logic        w_bitEnd;
    logic        w_loadTimer;
    logic        w_busy;
    logic        w_tx;

    assign w_push   = bus.wr_en && (bus.wr_port == PORT_DATA);
    assign w_flush  = bus.wr_en && (bus.wr_port == PORT_CTRL) && bus.wr_data[CTRL_FLUSH];
    assign w_clrOvf = bus.wr_en && (bus.wr_port == PORT_CTRL) && bus.wr_data[CTRL_CLR_OVF];
    assign w_bitEnd = (r_timer == 16'd1);
    assign w_busy   = (r_state != ST_IDLE);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (bus.wr_data),
        .o_data  (w_fifoData),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div      <= CLK_DIV;
            r_overflow <= 1'b0;
        end else begin
            if (bus.wr_en && (bus.wr_port == PORT_DIV_LO)) r_div[7:0]  <= bus.wr_data;
            if (bus.wr_en && (bus.wr_port == PORT_DIV_HI)) r_div[15:8] <= bus.wr_data;
            if (w_clrOvf)
                r_overflow <= 1'b0;
            else if (w_push && w_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_loadTimer = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_loadTimer = 1'b1;
                    w_nextState = ST_START;
                end
            end
            ST_START: begin
                if (w_bitEnd) begin
                    w_loadTimer = 1'b1;
                    w_nextState = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bitEnd) begin
                    w_loadTimer = 1'b1;
                    if (r_bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_nextState = ST_PARITY;
`else
                        w_nextState = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bitEnd) begin
                    w_loadTimer = 1'b1;
                    w_nextState = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Chain straight into the next start bit so queued bytes leave gap-free.
                if (w_bitEnd) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_loadTimer = 1'b1;
                        w_nextState = ST_START;
                    end else begin
                        w_nextState = ST_IDLE;
                    end
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer  <= 16'd0;
            r_shift  <= 8'd0;
            r_bitIdx <= 3'd0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            if (w_loadTimer)
                r_timer <= effDivisor(r_div);
            else if (r_state != ST_IDLE)
                r_timer <= r_timer - 16'd1;

            if (w_pop) begin
                r_shift  <= w_fifoData;
                r_bitIdx <= 3'd0;
`ifdef UART_TX_PARITY_EN
                r_parity <= ^w_fifoData;
`endif
            end else if ((r_state == ST_DATA) && w_bitEnd) begin
                r_shift  <= {1'b0, r_shift[7:1]};
                r_bitIdx <= r_bitIdx + 3'd1;
            end
        end
    end

    // Line level is decoded from state so reset forces it high without waiting for a clock.
    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            ST_START:  w_tx = 1'b0;
            ST_DATA:   w_tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx = r_parity;
`endif
            default:   w_tx = 1'b1;
        endcase
    end

    assign bus.tx     = w_tx;
    assign bus.status = {1'b0, w_count, r_overflow, w_busy, w_empty, w_full};

endmodule
